// File: rtl/mult_share_arbiter_if.sv
// Handshake bundle between requesters, the shared-multiplier arbiter and the multiplier port.
// master: arbiter side; slave: requesters plus multiplier side.
interface mult_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 4,
  parameter int B_W     = 4,
  parameter int Z_W     = A_W + B_W + 2
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [Z_W-1:0]         rsp_z;
  logic                   rsp_err;
  logic [NUM_REQ-1:0]     rsp_ready;
  logic [A_W-1:0]         m_a;
  logic [B_W-1:0]         m_b;
  logic                   m_ab_valid;
  logic                   m_ab_ready;
  logic                   m_z_valid;
  logic [Z_W-1:0]         m_z;
  logic                   busy;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready, m_ab_ready, m_z_valid, m_z,
    output req_ready, rsp_valid, rsp_z, rsp_err, m_a, m_b, m_ab_valid, busy
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ready, m_ab_ready, m_z_valid, m_z,
    input  req_ready, rsp_valid, rsp_z, rsp_err, m_a, m_b, m_ab_valid, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler sharing one sequential multiplier among NUM_REQ requesters,
// one operation in flight at a time, with a WAIT-state timeout that returns an error response.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 4,
  parameter int B_W     = 4,
  parameter int Z_W     = A_W + B_W + 2,
  parameter int TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  mult_share_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W:0]   N_L      = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_hit;
  logic [IDX_W:0]     cand;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] gnt_oh;

  logic accept;
  logic issue_done;
  logic z_take;
  logic t_out;
  logic rsp_done;

  // Rotating priority: scan upward from ptr, wrapping modulo NUM_REQ.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= N_L) cand = cand - N_L;
      if (!arb_hit && bus.req_valid[cand[IDX_W-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && arb_hit) bus.req_ready[arb_idx] = 1'b1;
  end

  always_comb begin
    gnt_oh      = '0;
    gnt_oh[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    issue_done = 1'b0;
    z_take     = 1'b0;
    t_out      = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        if (arb_hit) begin
          accept   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_ab_ready) begin
          issue_done = 1'b1;
          state_nx   = WAIT;
        end
      end
      WAIT: begin
        // A result arriving on the final timeout cycle still wins over the abort.
        if (bus.m_z_valid) begin
          z_take   = 1'b1;
          state_nx = RESP;
        end else if (cnt == TO_LAST) begin
          t_out    = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready[gnt]) begin
          rsp_done = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr            <= '0;
      gnt            <= '0;
      cnt            <= '0;
      bus.m_a        <= '0;
      bus.m_b        <= '0;
      bus.m_ab_valid <= 1'b0;
      bus.rsp_valid  <= '0;
      bus.rsp_z      <= '0;
      bus.rsp_err    <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.busy <= (state_nx != IDLE);

      if (accept) begin
        gnt            <= arb_idx;
        bus.m_a        <= bus.req_a[arb_idx*A_W +: A_W];
        bus.m_b        <= bus.req_b[arb_idx*B_W +: B_W];
        bus.m_ab_valid <= 1'b1;
        ptr            <= (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
      end

      if (issue_done) begin
        bus.m_ab_valid <= 1'b0;
        cnt            <= '0;
      end else if (state == WAIT && state_nx == WAIT) begin
        cnt <= cnt + 1'b1;
      end

      if (z_take) begin
        bus.rsp_z     <= bus.m_z;
        bus.rsp_err   <= 1'b0;
        bus.rsp_valid <= gnt_oh;
      end else if (t_out) begin
        bus.rsp_z     <= '0;
        bus.rsp_err   <= 1'b1;
        bus.rsp_valid <= gnt_oh;
      end else if (rsp_done) begin
        bus.rsp_valid <= '0;
        bus.rsp_err   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter; the bench plays requesters and the multiplier.
module tb_mult_share_arbiter;
  localparam int TO = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mult_share_arbiter_if #(.NUM_REQ(4), .A_W(4), .B_W(4), .Z_W(10)) bus ();

  mult_share_arbiter #(
    .NUM_REQ(4), .A_W(4), .B_W(4), .Z_W(10), .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one complete operation as requester/multiplier; reports what the DUT did.
  task automatic run_op(input int lat, output int gidx, output logic [3:0] oa,
                        output logic [3:0] ob, output logic [9:0] z,
                        output logic err, output logic [3:0] rv);
    int n;
    gidx = -1; oa = '0; ob = '0; z = '1; err = 1'b1; rv = '0;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 16) begin step(); n++; end
    if (bus.req_ready == '0) return;
    for (int i = 0; i < 4; i++) if (bus.req_ready[i]) gidx = i;
    step();
    oa = bus.m_a; ob = bus.m_b;
    bus.m_ab_ready = 1'b1;
    step();
    bus.m_ab_ready = 1'b0;
    repeat (lat) step();
    bus.m_z_valid = 1'b1;
    bus.m_z = {6'b0, oa} * {6'b0, ob};
    step();
    bus.m_z_valid = 1'b0;
    n = 0;
    while (bus.rsp_valid == '0 && n < 16) begin step(); n++; end
    if (bus.rsp_valid == '0) return;
    z = bus.rsp_z; err = bus.rsp_err; rv = bus.rsp_valid;
    bus.rsp_ready = bus.rsp_valid;
    step();
    bus.rsp_ready = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = '0;
    bus.m_ab_ready = 1'b0; bus.m_z_valid = 1'b0; bus.m_z = '0;
    repeat (3) step();
    total++; if ({bus.m_a, bus.m_b, bus.m_ab_valid} !== 9'h0) begin bad++;
      $display("FAIL reset_mport: got a=%0h b=%0h v=%0b want 0", bus.m_a, bus.m_b, bus.m_ab_valid); end
    total++; if ({bus.rsp_valid, bus.rsp_z, bus.rsp_err} !== 15'h0) begin bad++;
      $display("FAIL reset_rsp: got v=%0h z=%0h e=%0b want 0", bus.rsp_valid, bus.rsp_z, bus.rsp_err); end
    total++; if ({bus.busy, bus.req_ready} !== 5'h0) begin bad++;
      $display("FAIL reset_busy_ready: got busy=%0b ready=%0h want 0", bus.busy, bus.req_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_round_robin();
    int         g;
    logic [3:0] oa, ob, rv;
    logic [9:0] z;
    logic       err;
    int         exp_g [5] = '{0, 1, 2, 3, 0};
    int         exp_z [5] = '{225, 15, 14, 99, 225};
    bus.req_a = {4'd9, 4'd7, 4'd3, 4'd15};
    bus.req_b = {4'd11, 4'd2, 4'd5, 4'd15};
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_op(k % 3, g, oa, ob, z, err, rv);
      total++; if (g !== exp_g[k]) begin bad++;
        $display("FAIL rr_grant[%0d]: got %0d want %0d", k, g, exp_g[k]); end
      total++; if (z !== 10'(exp_z[k])) begin bad++;
        $display("FAIL rr_z[%0d]: got %0d want %0d", k, z, exp_z[k]); end
      total++; if ({err, rv} !== {1'b0, 4'(1 << exp_g[k])}) begin bad++;
        $display("FAIL rr_rsp[%0d]: got err=%0b v=%0h want err=0 v=%0h", k, err, rv, 4'(1 << exp_g[k])); end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_single_op();
    bus.req_valid = 4'b0100; bus.req_a = 16'h0500; bus.req_b = 16'h0300;
    #1;
    total++; if (bus.req_ready !== 4'b0100) begin bad++;
      $display("FAIL single_ready: got %0h want 4", bus.req_ready); end
    step();
    bus.req_valid = '0;
    total++; if ({bus.m_ab_valid, bus.m_a, bus.m_b, bus.busy} !== {1'b1, 4'd5, 4'd3, 1'b1}) begin bad++;
      $display("FAIL single_issue: got v=%0b a=%0d b=%0d busy=%0b want v=1 a=5 b=3 busy=1",
               bus.m_ab_valid, bus.m_a, bus.m_b, bus.busy); end
    bus.m_ab_ready = 1'b1; step(); bus.m_ab_ready = 1'b0;
    total++; if (bus.m_ab_valid !== 1'b0) begin bad++;
      $display("FAIL single_ab_drop: got %0b want 0", bus.m_ab_valid); end
    step();
    bus.m_z_valid = 1'b1; bus.m_z = 10'd15;
    #1;
    total++; if (bus.rsp_valid !== 4'b0000) begin bad++;
      $display("FAIL single_rsp_early: got %0h want 0", bus.rsp_valid); end
    step();
    bus.m_z_valid = 1'b0;
    total++; if ({bus.rsp_valid, bus.rsp_z, bus.rsp_err} !== {4'b0100, 10'd15, 1'b0}) begin bad++;
      $display("FAIL single_rsp: got v=%0h z=%0d e=%0b want v=4 z=15 e=0", bus.rsp_valid, bus.rsp_z, bus.rsp_err); end
    bus.rsp_ready = 4'b0100; step(); bus.rsp_ready = '0;
    total++; if ({bus.rsp_valid, bus.busy} !== 5'h0) begin bad++;
      $display("FAIL single_done: got v=%0h busy=%0b want 0", bus.rsp_valid, bus.busy); end
  endtask

  task automatic test_backpressure();
    int stable_err;
    bus.req_valid = 4'b0010; bus.req_a = 16'h2060; bus.req_b = 16'h2070;
    #1; step();
    bus.req_valid = 4'b1000;
    #1;
    stable_err = 0;
    repeat (5) begin
      if (!(bus.m_ab_valid === 1'b1 && bus.m_a === 4'd6 && bus.m_b === 4'd7 && bus.req_ready === 4'b0000))
        stable_err++;
      step();
    end
    total++; if (stable_err !== 0) begin bad++;
      $display("FAIL bp_issue_hold: got %0d unstable cycles want 0", stable_err); end
    bus.m_ab_ready = 1'b1; step(); bus.m_ab_ready = 1'b0;
    total++; if (bus.m_ab_valid !== 1'b0) begin bad++;
      $display("FAIL bp_single_issue: got %0b want 0", bus.m_ab_valid); end
    bus.m_z_valid = 1'b1; bus.m_z = 10'd42; step(); bus.m_z_valid = 1'b0;
    bus.rsp_ready = 4'b1101;
    stable_err = 0;
    repeat (7) begin
      if (!(bus.rsp_valid === 4'b0010 && bus.rsp_z === 10'd42 && bus.req_ready === 4'b0000 && bus.busy === 1'b1))
        stable_err++;
      step();
    end
    total++; if (stable_err !== 0) begin bad++;
      $display("FAIL bp_rsp_hold: got %0d unstable cycles want 0", stable_err); end
    bus.rsp_ready = 4'b0010; step(); bus.rsp_ready = '0;
    total++; if ({bus.rsp_valid, bus.req_ready} !== {4'b0000, 4'b1000}) begin bad++;
      $display("FAIL bp_next_grant: got v=%0h ready=%0h want v=0 ready=8", bus.rsp_valid, bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_timeout();
    bus.req_valid = 4'b0001; bus.req_a = 16'h0009; bus.req_b = 16'h0009;
    #1; step();
    bus.req_valid = '0;
    bus.m_ab_ready = 1'b1; step(); bus.m_ab_ready = 1'b0;
    repeat (TO - 1) step();
    total++; if ({bus.rsp_valid, bus.busy} !== {4'b0000, 1'b1}) begin bad++;
      $display("FAIL to_early: got v=%0h busy=%0b want v=0 busy=1", bus.rsp_valid, bus.busy); end
    step();
    total++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_z} !== {4'b0001, 1'b1, 10'd0}) begin bad++;
      $display("FAIL to_rsp: got v=%0h e=%0b z=%0d want v=1 e=1 z=0", bus.rsp_valid, bus.rsp_err, bus.rsp_z); end
    bus.m_z_valid = 1'b1; bus.m_z = 10'd81; step(); bus.m_z_valid = 1'b0;
    total++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_z} !== {4'b0001, 1'b1, 10'd0}) begin bad++;
      $display("FAIL to_late_resp: got v=%0h e=%0b z=%0d want v=1 e=1 z=0", bus.rsp_valid, bus.rsp_err, bus.rsp_z); end
    bus.rsp_ready = 4'b0001; step(); bus.rsp_ready = '0;
    bus.m_z_valid = 1'b1; step(); bus.m_z_valid = 1'b0;
    total++; if ({bus.rsp_valid, bus.rsp_err, bus.busy} !== 6'h0) begin bad++;
      $display("FAIL to_late_idle: got v=%0h e=%0b busy=%0b want 0", bus.rsp_valid, bus.rsp_err, bus.busy); end
  endtask

  task automatic test_spurious();
    int         g;
    logic [3:0] oa, ob, rv;
    logic [9:0] z;
    logic       err;
    bus.req_valid = 4'b0100; bus.req_a = 16'h0400; bus.req_b = 16'h0400;
    run_op(1, g, oa, ob, z, err, rv);
    bus.req_valid = '0;
    total++; if ({g[2:0], z} !== {3'd2, 10'd16}) begin bad++;
      $display("FAIL sp_setup: got g=%0d z=%0d want g=2 z=16", g, z); end
    bus.m_z_valid = 1'b1; bus.m_z = 10'd99; step(); bus.m_z_valid = 1'b0;
    total++; if ({bus.rsp_valid, bus.rsp_z, bus.busy} !== {4'b0000, 10'd16, 1'b0}) begin bad++;
      $display("FAIL sp_idle: got v=%0h z=%0d busy=%0b want v=0 z=16 busy=0", bus.rsp_valid, bus.rsp_z, bus.busy); end
    bus.req_valid = 4'b1000; bus.req_a = 16'h2000; bus.req_b = 16'h3000;
    #1; step();
    bus.req_valid = '0;
    bus.m_z_valid = 1'b1; bus.m_z = 10'd99; step(); bus.m_z_valid = 1'b0;
    total++; if ({bus.rsp_valid, bus.rsp_z, bus.m_ab_valid} !== {4'b0000, 10'd16, 1'b1}) begin bad++;
      $display("FAIL sp_issue: got v=%0h z=%0d abv=%0b want v=0 z=16 abv=1", bus.rsp_valid, bus.rsp_z, bus.m_ab_valid); end
    bus.m_ab_ready = 1'b1; step(); bus.m_ab_ready = 1'b0;
    bus.m_z_valid = 1'b1; bus.m_z = 10'd6; step(); bus.m_z_valid = 1'b0;
    total++; if ({bus.rsp_valid, bus.rsp_z} !== {4'b1000, 10'd6}) begin bad++;
      $display("FAIL sp_after: got v=%0h z=%0d want v=8 z=6", bus.rsp_valid, bus.rsp_z); end
    bus.rsp_ready = 4'b1000; step(); bus.rsp_ready = '0;
  endtask

  task automatic test_reset_mid_wait();
    int         g;
    logic [3:0] oa, ob, rv;
    logic [9:0] z;
    logic       err;
    bus.req_valid = 4'b0100; bus.req_a = 16'h0300; bus.req_b = 16'h0300;
    #1; step();
    bus.req_valid = '0;
    bus.m_ab_ready = 1'b1; step(); bus.m_ab_ready = 1'b0;
    step();
    total++; if ({bus.busy, bus.m_ab_valid, bus.rsp_valid} !== {1'b1, 1'b0, 4'b0000}) begin bad++;
      $display("FAIL rst_pre_wait: got busy=%0b abv=%0b v=%0h want busy=1 abv=0 v=0",
               bus.busy, bus.m_ab_valid, bus.rsp_valid); end
    rst_n = 1'b0;
    #1;
    total++; if ({bus.m_a, bus.m_b, bus.m_ab_valid, bus.busy} !== 10'h0) begin bad++;
      $display("FAIL rst_async_m: got a=%0h b=%0h v=%0b busy=%0b want 0", bus.m_a, bus.m_b, bus.m_ab_valid, bus.busy); end
    total++; if ({bus.rsp_valid, bus.rsp_z, bus.rsp_err} !== 15'h0) begin bad++;
      $display("FAIL rst_async_rsp: got v=%0h z=%0h e=%0b want 0", bus.rsp_valid, bus.rsp_z, bus.rsp_err); end
    step(); step();
    rst_n = 1'b1;
    step();
    bus.req_valid = 4'b1010; bus.req_a = 16'h1080; bus.req_b = 16'h1090;
    #1;
    total++; if (bus.req_ready !== 4'b0010) begin bad++;
      $display("FAIL rst_ptr_zero: got ready=%0h want 2", bus.req_ready); end
    bus.req_valid = 4'b0010;
    run_op(2, g, oa, ob, z, err, rv);
    bus.req_valid = '0;
    total++; if (g !== 1) begin bad++;
      $display("FAIL rst_after_grant: got %0d want 1", g); end
    total++; if ({z, err, rv} !== {10'd72, 1'b0, 4'b0010}) begin bad++;
      $display("FAIL rst_after_rsp: got z=%0d e=%0b v=%0h want z=72 e=0 v=2", z, err, rv); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_round_robin();
    test_single_op();
    test_backpressure();
    test_timeout();
    test_spurious();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
